fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the 16-bit synchronous single-port memory (1000 words, registered read output).
- Owns the program counter and drives the memory address.
- Absorbs the memory's one-cycle read latency and presents each instruction word to decode through a valid/ready handshake.
- Supports branch redirect with in-flight flush, halt, and an out-of-range address error flag.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a single-port memory with one-cycle
// read latency and hands each word to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        DATA_W    = 16,
    parameter int unsigned        MEM_DEPTH = 1000,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_err,
    output logic [15:0]       fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FULL
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [15:0]       count_q, count_d;

    logic [ADDR_W-1:0] pc_inc;
    logic              redirect_oob;

    assign pc_inc       = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    assign redirect_oob = redirect_pc > LAST_PC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                instr_d    = mem_rdata;
                instr_pc_d = pc_q;
                valid_d    = 1'b1;
                pc_d       = pc_inc;
                state_d    = S_FULL;
            end
            S_FULL: begin
                if (instr_ready) begin
                    count_d = count_q + 16'd1;
                    valid_d = 1'b0;
                    state_d = halt ? S_IDLE : S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides the step above, but a handshake completing in FULL still counts.
        if (redirect_valid) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            valid_d    = 1'b0;
            pc_d       = redirect_oob ? '0 : redirect_pc;
            if (redirect_oob) err_d = 1'b1;
            state_d    = halt ? S_IDLE : S_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign mem_addr    = pc_q;
    assign mem_we      = 1'b0;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = err_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table, directed multi-cycle sequences and
// a randomized run scored against a transaction-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        fetch_err;
    logic [15:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .MEM_DEPTH(1000),
        .RESET_PC (16'd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_err     (fetch_err),
        .fetch_count   (fetch_count)
    );

    // Default memory image: words 0..9 hold (n+1)<<12, the rest hold their own address.
    function automatic logic [15:0] img(input logic [15:0] a);
        return (a < 16'd10) ? ((a + 16'd1) << 12) : a;
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] a);
        return (a == 16'd999) ? 16'd0 : a + 16'd1;
    endfunction

    // Registered-read memory
    always @(posedge clk) if (!mem_we) mem_rdata <= img(mem_addr);

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for a valid word, checks it, lets the edge pass.
    task automatic wait_deliver(input string name, input logic [15:0] ei, input logic [15:0] ep);
        int unsigned n = 0;
        while (!instr_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check1({name, "_arrived"}, instr_valid, 1'b1);
        check16({name, "_instr"}, instr, ei);
        check16({name, "_pc"}, instr_pc, ep);
        if (instr_valid && instr_ready) exp_cnt++;
        @(negedge clk);
    endtask

    typedef struct {
        logic        h, r, rv;
        logic [15:0] rpc;
        logic        v;
        logic [15:0] ins, ipc, addr, cnt;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int h, int r, int rv, int rpc, int v, int ins,
                                int ipc, int addr, int cnt, int err);
        vec_t m;
        m.h = h[0];  m.r = r[0];  m.rv = rv[0];  m.rpc = rpc[15:0];
        m.v = v[0];  m.ins = ins[15:0];  m.ipc = ipc[15:0];
        m.addr = addr[15:0];  m.cnt = cnt[15:0];  m.err = err[0];
        return m;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_pc;
        logic        exp_err;
        logic        hs, hold;
        logic [15:0] p_instr, p_ipc;
        int unsigned run;
        int unsigned sel;

        //            h r rv rpc   v ins      ipc addr cnt err
        vecs.push_back(mk(0,1,0,0,    0,16'h0000,0, 0,  0,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h0000,0, 0,  0,  0));
        vecs.push_back(mk(0,1,0,0,    1,16'h1000,0, 1,  0,  0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,0,0,0,1,16'h1000,0, 1,  0,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h1000,0, 1,  1,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h1000,0, 1,  1,  0));
        vecs.push_back(mk(0,1,0,0,    1,16'h2000,1, 2,  1,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h2000,1, 2,  2,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h2000,1, 2,  2,  0));
        vecs.push_back(mk(0,1,0,0,    1,16'h3000,2, 3,  2,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h3000,2, 3,  3,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h3000,2, 3,  3,  0));
        vecs.push_back(mk(0,1,1,12,   0,16'h3000,2, 12, 3,  0));
        vecs.push_back(mk(0,1,0,0,    0,16'h3000,2, 12, 3,  0));
        vecs.push_back(mk(0,1,0,0,    1,16'h000C,12,13, 3,  0));
        vecs.push_back(mk(0,1,1,1500, 0,16'h000C,12,0,  4,  1));
        vecs.push_back(mk(0,1,0,0,    0,16'h000C,12,0,  4,  1));
        vecs.push_back(mk(0,1,0,0,    1,16'h1000,0, 1,  4,  1));
        vecs.push_back(mk(1,1,0,0,    0,16'h1000,0, 1,  5,  1));
        vecs.push_back(mk(1,1,0,0,    0,16'h1000,0, 1,  5,  1));
        vecs.push_back(mk(0,1,0,0,    0,16'h1000,0, 1,  5,  1));
        vecs.push_back(mk(0,1,0,0,    0,16'h1000,0, 1,  5,  1));
        vecs.push_back(mk(0,1,0,0,    1,16'h2000,1, 2,  5,  1));

        repeat (2) @(negedge clk);
        check1 ("rst_valid", instr_valid, 1'b0);
        check16("rst_instr", instr, 16'h0000);
        check16("rst_ipc",   instr_pc, 16'h0000);
        check16("rst_addr",  mem_addr, 16'h0000);
        check16("rst_count", fetch_count, 16'h0000);
        check1 ("rst_err",   fetch_err, 1'b0);
        check1 ("rst_we",    mem_we, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            halt = vecs[i].h;  instr_ready = vecs[i].r;
            redirect_valid = vecs[i].rv;  redirect_pc = vecs[i].rpc;
            @(posedge clk); #1;
            check1 ($sformatf("v%0d_valid", i), instr_valid, vecs[i].v);
            check16($sformatf("v%0d_instr", i), instr, vecs[i].ins);
            check16($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].ipc);
            check16($sformatf("v%0d_addr", i),  mem_addr, vecs[i].addr);
            check16($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
            check1 ($sformatf("v%0d_err", i),   fetch_err, vecs[i].err);
            @(negedge clk);
        end
        exp_cnt = 16'd5;

        // Redirect to 998 while a word waits unaccepted, then run through the wrap.
        instr_ready = 1'b0;  redirect_valid = 1'b1;  redirect_pc = 16'd998;
        @(negedge clk);
        redirect_valid = 1'b0;  instr_ready = 1'b1;
        wait_deliver("wrap998", 16'h03E6, 16'd998);
        wait_deliver("wrap999", 16'h03E7, 16'd999);
        wait_deliver("wrap0",   16'h1000, 16'd0);
        check16("wrap_count", fetch_count, exp_cnt);

        // Halt raised while the next fetch is in ISSUE.
        halt = 1'b1;
        wait_deliver("halt_inflight", 16'h2000, 16'd1);
        check1 ("halt_idle_valid", instr_valid, 1'b0);
        check16("halt_count", fetch_count, exp_cnt);
        repeat (4) begin
            @(negedge clk);
            check16("halt_addr_frozen", mem_addr, 16'd2);
            check1 ("halt_no_valid", instr_valid, 1'b0);
        end
        halt = 1'b0;
        wait_deliver("halt_resume", 16'h3000, 16'd2);

        // Reset while a word sits in FULL.
        instr_ready = 1'b0;
        for (int n = 0; n < 10 && !instr_valid; n++) @(negedge clk);
        check1 ("prerst_valid", instr_valid, 1'b1);
        check16("prerst_instr", instr, 16'h4000);
        rst_n = 1'b0;
        #1;
        check1 ("midrst_valid", instr_valid, 1'b0);
        check16("midrst_count", fetch_count, 16'h0000);
        check16("midrst_addr",  mem_addr, 16'h0000);
        check1 ("midrst_err",   fetch_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;  instr_ready = 1'b1;
        @(posedge clk); #1;
        check1("lat_c1_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        check1("lat_c2_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        check1 ("lat_c3_valid", instr_valid, 1'b1);
        check16("lat_c3_instr", instr, 16'h1000);
        check16("lat_c3_ipc",   instr_pc, 16'h0000);

        // Randomized run: the model tracks only the next PC owed to decode,
        // the accepted count and the sticky error.
        exp_pc = 16'd0;  exp_cnt = 16'd0;  exp_err = 1'b0;  run = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            halt           = ($urandom_range(0, 9) == 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       redirect_pc = 16'($urandom_range(0, 999));
                1:       redirect_pc = 16'($urandom_range(990, 999));
                2:       redirect_pc = 16'($urandom_range(1000, 65535));
                default: redirect_pc = 16'($urandom_range(0, 20));
            endcase

            hs = instr_valid && instr_ready;
            if (hs) begin
                check16("rnd_instr", instr, img(exp_pc));
                check16("rnd_ipc",   instr_pc, exp_pc);
                exp_cnt++;
                exp_pc = nxt(exp_pc);
            end
            if (redirect_valid) begin
                if (redirect_pc >= 16'd1000) begin
                    exp_pc  = 16'd0;
                    exp_err = 1'b1;
                end else begin
                    exp_pc = redirect_pc;
                end
            end
            hold    = instr_valid && !instr_ready && !redirect_valid;
            p_instr = instr;
            p_ipc   = instr_pc;
            if (!halt && instr_ready && !redirect_valid && !hs) run++;
            else run = 0;

            @(posedge clk); #1;
            check16("rnd_count", fetch_count, exp_cnt);
            check1 ("rnd_err",   fetch_err, exp_err);
            check1 ("rnd_we",    mem_we, 1'b0);
            check1 ("rnd_progress", run <= 3, 1'b1);
            if (hold) begin
                check1 ("rnd_hold_valid", instr_valid, 1'b1);
                check16("rnd_hold_instr", instr, p_instr);
                check16("rnd_hold_ipc",   instr_pc, p_ipc);
            end
            if (instr_valid) check16("rnd_addr_ahead", mem_addr, nxt(instr_pc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
